add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arb_pkg.sv | 15 +
 rtl/add_arb_pick.sv | 25 ++
 rtl/add_arbiter.sv | 134 +++++++++++++
 tb/tb_add_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// Shared types and default sizing for the add_arbiter slice.
package add_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 4;
  localparam int DEF_ADD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/add_arb_pick.sv
// Combinational winner select: first set request found scanning upward from ptr.
module add_arb_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win
);

  always_comb begin
    logic found;
    int   idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Arbitrates N_REQ requesters onto one shared, externally-latent adder.
// Define ADD_ARB_RR_EN for round-robin; default build is fixed priority (index 0 highest).
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int ADD_LAT = DEF_ADD_LAT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N_REQ-1:0]   Req,
  input  logic [N_REQ*W-1:0] ReqA,
  input  logic [N_REQ*W-1:0] ReqB,
  output logic [N_REQ-1:0]   Gnt,
  output logic [N_REQ-1:0]   Done,
  output logic [W-1:0]       RespSum,
  output logic               RespOverflow,
  output logic               Busy,
  output logic [W-1:0]       AdderA,
  output logic [W-1:0]       AdderB,
  output logic               AdderEn,
  input  logic [W-1:0]       AdderSum,
  input  logic               AdderOverflow
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] win, gnt_q;
  logic [W-1:0]     sel_a, sel_b, op_a, op_b, sum_q;
  logic             ovf_q;
  logic [2:0]       cnt;
  logic [PW-1:0]    ptr;
  logic             take;

  assign take = (state == IDLE) && (|Req);

  add_arb_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req (Req),
    .ptr (ptr),
    .win (win)
  );

`ifdef ADD_ARB_RR_EN
  logic [PW-1:0] win_idx;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win[i]) win_idx = PW'(i);
  end

  // Next search starts just past the last winner.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)     ptr <= '0;
    else if (take) ptr <= (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
  end
`else
  assign ptr = '0;
`endif

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win[i]) begin
        sel_a = ReqA[i*W +: W];
        sel_b = ReqB[i*W +: W];
      end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|Req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt counts down the remaining adder cycles; result is sampled when it hits zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gnt_q <= '0;
      op_a  <= '0;
      op_b  <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          gnt_q <= win;
          op_a  <= sel_a;
          op_b  <= sel_b;
        end
        ISSUE: cnt <= 3'(ADD_LAT - 1);
        WAIT: begin
          if (cnt == 3'd0) begin
            sum_q <= AdderSum;
            ovf_q <= AdderOverflow;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          gnt_q <= '0;
          sum_q <= '0;
          ovf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state so Reset clears them without a clock.
  assign Gnt          = gnt_q;
  assign Busy         = (state != IDLE);
  assign AdderEn      = (state == ISSUE);
  assign AdderA       = (state == ISSUE || state == WAIT) ? op_a : '0;
  assign AdderB       = (state == ISSUE || state == WAIT) ? op_b : '0;
  assign Done         = (state == DONE) ? gnt_q : '0;
  assign RespSum      = (state == DONE) ? sum_q : '0;
  assign RespOverflow = (state == DONE) ? ovf_q : 1'b0;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter (N_REQ=4, W=4, ADD_LAT=1) with a 1-cycle adder model.
module tb_add_arbiter;

  localparam int NR  = 4;
  localparam int WD  = 4;
  localparam int LAT = 1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [NR-1:0]     Req;
  logic [NR*WD-1:0]  ReqA, ReqB;
  logic [NR-1:0]     Gnt, Done;
  logic [WD-1:0]     RespSum, AdderA, AdderB, AdderSum;
  logic              RespOverflow, Busy, AdderEn, AdderOverflow;

  int n_vec = 0;
  int n_err = 0;

  add_arbiter #(.N_REQ(NR), .W(WD), .ADD_LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqA(ReqA), .ReqB(ReqB),
    .Gnt(Gnt), .Done(Done), .RespSum(RespSum), .RespOverflow(RespOverflow),
    .Busy(Busy), .AdderA(AdderA), .AdderB(AdderB), .AdderEn(AdderEn),
    .AdderSum(AdderSum), .AdderOverflow(AdderOverflow)
  );

  always #5 Clk = ~Clk;

  // Shared adder: registers sum and signed-overflow flag one cycle after AdderEn.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      AdderSum      <= '0;
      AdderOverflow <= 1'b0;
    end else if (AdderEn) begin
      AdderSum      <= AdderA + AdderB;
      AdderOverflow <= (AdderA[WD-1] == AdderB[WD-1]) &&
                       (WD'(AdderA + AdderB) >> (WD-1) != {{(WD-1){1'b0}}, AdderA[WD-1]});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic do_op(input string tag, input logic [3:0] rq, input logic [15:0] ra, rb,
                       input logic [3:0] eg, ea, eb, es, input logic eo,
                       input bit drop, input bit clr_end);
    Req = rq; ReqA = ra; ReqB = rb;
    @(posedge Clk);
    @(negedge Clk);
    chk({tag, ".en"},   AdderEn, 1'b1);
    chk({tag, ".gnt"},  Gnt, eg);
    chk({tag, ".a"},    AdderA, ea);
    chk({tag, ".b"},    AdderB, eb);
    chk({tag, ".busy"}, Busy, 1'b1);
    if (drop) begin
      Req  = '0;
      ReqA = ~ra;
      ReqB = ~rb;
    end
    for (int c = 2; c <= LAT + 1; c++) begin
      @(negedge Clk);
      chk({tag, ".wen"},  AdderEn, 1'b0);
      chk({tag, ".wa"},   AdderA, ea);
      chk({tag, ".wdn"},  Done, 4'b0);
      chk({tag, ".wsum"}, RespSum, 4'b0);
    end
    @(negedge Clk);
    chk({tag, ".done"}, Done, eg);
    chk({tag, ".sum"},  RespSum, es);
    chk({tag, ".ovf"},  RespOverflow, eo);
    @(negedge Clk);
    chk({tag, ".idn"},  Done, 4'b0);
    chk({tag, ".igt"},  Gnt, 4'b0);
    chk({tag, ".ibsy"}, Busy, 1'b0);
    chk({tag, ".isum"}, RespSum, 4'b0);
    if (clr_end) Req = '0;
  endtask

  logic [3:0] ord_g [4];
  logic [3:0] ord_a [4];
  logic [3:0] ord_s [4];

  initial begin
`ifdef ADD_ARB_RR_EN
    ord_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ord_a = '{4'd1, 4'd2, 4'd3, 4'd4};
    ord_s = '{4'd2, 4'd3, 4'd4, 4'd5};
`else
    ord_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    ord_a = '{4'd1, 4'd1, 4'd1, 4'd1};
    ord_s = '{4'd2, 4'd2, 4'd2, 4'd2};
`endif
    Reset = 1'b1; Req = '0; ReqA = '0; ReqB = '0;
    #1;
    chk("rst.gnt", Gnt, 4'b0);
    chk("rst.busy", Busy, 1'b0);
    chk("rst.en", AdderEn, 1'b0);
    chk("rst.done", Done, 4'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Quiet requesters: nothing moves.
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk("idle.busy", Busy, 1'b0);
      chk("idle.en", AdderEn, 1'b0);
    end

    do_op("add37", 4'b0001, 16'h0003, 16'h0004, 4'b0001, 4'd3, 4'd4, 4'd7, 1'b0, 0, 1);
    do_op("ovf71", 4'b0001, 16'h0007, 16'h0001, 4'b0001, 4'd7, 4'd1, 4'd8, 1'b1, 0, 1);

    // Fresh pointer, then four back-to-back ops with all requests held.
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 4; i++)
      do_op($sformatf("all%0d", i), 4'b1111, 16'h4321, 16'h1111,
            ord_g[i], ord_a[i], 4'd1, ord_s[i], 1'b0, 0, i == 3);

    do_op("drop", 4'b0100, 16'h0500, 16'h0200, 4'b0100, 4'd5, 4'd2, 4'd7, 1'b0, 1, 1);

    // Abort in WAIT: everything clears without a clock edge and no Done follows.
    Req = 4'b0001; ReqA = 16'h0001; ReqB = 16'h0001;
    @(posedge Clk);
    @(posedge Clk);
    #2;
    chk("abort.busy0", Busy, 1'b1);
    Reset = 1'b1;
    #1;
    chk("abort.gnt", Gnt, 4'b0);
    chk("abort.busy", Busy, 1'b0);
    chk("abort.a", AdderA, 4'd0);
    chk("abort.en", AdderEn, 1'b0);
    chk("abort.sum", RespSum, 4'd0);
    Req = '0;
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("abort.nodone", Done, 4'b0);
    end

    do_op("post", 4'b0010, 16'h0060, 16'h0020, 4'b0010, 4'd6, 4'd2, 4'd8, 1'b1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
